// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core MEM-stage port and a debug/loader port.
// Round-robin arbitration with bounded bursts; load data is routed back one cycle after the grant.
module dmem_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_stall,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    owner_e        last_owner_q, last_owner_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          rsp_pending_q, rsp_pending_d;
    owner_e        rsp_owner_q, rsp_owner_d;

    logic          keep_burst;
    logic          gnt_any;
    owner_e        gnt_owner;

    // A zero burst count means nobody holds an open burst, so a tie goes to the other owner.
    assign keep_burst = (burst_q != '0) && (burst_q < BW'(MAX_BURST));

    // Grant selection; held off entirely while reset is asserted.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (c_req && d_req) begin
                if (keep_burst) begin
                    c_gnt = (last_owner_q == OWN_CORE);
                    d_gnt = (last_owner_q == OWN_DBG);
                end else begin
                    c_gnt = (last_owner_q == OWN_DBG);
                    d_gnt = (last_owner_q == OWN_CORE);
                end
            end else begin
                c_gnt = c_req;
                d_gnt = d_req;
            end
        end
    end

    assign gnt_any   = c_gnt | d_gnt;
    assign gnt_owner = d_gnt ? OWN_DBG : OWN_CORE;

    // Memory request mux, zero when idle.
    always_comb begin
        m_en    = gnt_any;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    assign c_stall = c_req & d_gnt;

    // Arbitration and response-tracking next state.
    always_comb begin
        last_owner_d  = last_owner_q;
        burst_d       = '0;
        rsp_pending_d = 1'b0;
        rsp_owner_d   = rsp_owner_q;
        if (gnt_any) begin
            last_owner_d  = gnt_owner;
            rsp_pending_d = ~m_we;
            rsp_owner_d   = gnt_owner;
            if (gnt_owner == last_owner_q) begin
                burst_d = (burst_q == BW'(MAX_BURST)) ? burst_q : burst_q + BW'(1);
            end else begin
                burst_d = BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q  <= OWN_DBG;
            burst_q       <= '0;
            rsp_pending_q <= 1'b0;
            rsp_owner_q   <= OWN_CORE;
        end else begin
            last_owner_q  <= last_owner_d;
            burst_q       <= burst_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_owner_q   <= rsp_owner_d;
        end
    end

    // Memory read data is steered only to the port that issued the load.
    assign c_rvalid = rsp_pending_q && (rsp_owner_q == OWN_CORE);
    assign d_rvalid = rsp_pending_q && (rsp_owner_q == OWN_DBG);
    assign c_rdata  = c_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule
